// File: rtl/axis_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_mem_responder_pkg
// Description : Shared types and constants for the AXI4 INCR-only memory
//               responder: write/read FSM state encodings, AXI response
//               codes and the word-index width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package axis_mem_responder_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of a word index into a C_MEM_WORDS-deep array (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axis_mem_responder_if
// Description : AXI4 (INCR-only subset) bus bundle between a master and the
//               memory responder. No ID, size, burst-type or user fields.
// Ports       : AW: awvalid/awready/awaddr/awlen
//               W : wvalid/wready/wdata/wstrb/wlast
//               B : bvalid/bready/bresp
//               AR: arvalid/arready/araddr/arlen
//               R : rvalid/rready/rdata/rlast/rresp
// Revision    : 1.0 - initial release
// ============================================================================
interface axis_mem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;
  logic [1:0]              rresp;

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arlen,
    input  rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rlast, rresp
  );

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arlen,
    output rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rlast, rresp
  );
endinterface
`default_nettype wire

// File: rtl/axis_mem_responder_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : axis_rd_skid
// Description : Two-entry valid/ready FIFO holding {rlast, rdata} read beats
//               between the RAM output register and the R channel. The head
//               entry is presented directly, so it is stable while stalled.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               in_valid/in_data   - push side (no ready: the producer
//                                    reserves space by watching count)
//               out_valid/out_ready/out_data - pop side
//               count          - current occupancy (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module axis_rd_skid #(
  parameter int WIDTH = 33
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             in_valid,
  input  wire logic [WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  wire logic             out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            count
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       cnt_kept;
  logic             push;
  logic             pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = slot0_q;
  assign count     = cnt_q;

  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    cnt_kept = cnt_q;
    pop      = out_valid & out_ready;
    // A push into a full buffer is only legal when the head leaves this cycle.
    push     = in_valid & ((cnt_q != 2'd2) | pop);
    if (pop) begin
      slot0_d  = slot1_q;
      cnt_kept = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_kept == 2'd0) slot0_d = in_data;
      else                  slot1_d = in_data;
    end
    cnt_d = cnt_kept + {1'b0, push};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : axis_mem_responder
// Description : AXI4 INCR-only slave memory model backed by a dual-port RAM.
//               One write burst and one read burst are served concurrently.
//               Word index = ((addr - C_BASE_ADDR) >> 2) mod C_MEM_WORDS,
//               incrementing per beat and wrapping silently.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset (forces all outputs 0)
//               s_axi  - axis_mem_responder_if.slave bus bundle
// Revision    : 1.0 - initial release
// ============================================================================
module axis_mem_responder
  import axis_mem_responder_pkg::*;
#(
  parameter int                            C_S_AXI_ADDR_WIDTH = 32,
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_MEM_WORDS        = 4096,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  axis_mem_responder_if.slave   s_axi
);

  localparam int IDX_W = idx_width(C_MEM_WORDS);
  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;

  function automatic logic [IDX_W-1:0] word_idx(input logic [C_S_AXI_ADDR_WIDTH-1:0] addr);
    logic [C_S_AXI_ADDR_WIDTH-1:0] off;
    off = addr - C_BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  logic [DW-1:0] mem [C_MEM_WORDS];

  // ---------------------------------------------------------------- write --
  w_state_e         w_state_q, w_state_d;
  logic [IDX_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]       w_len_q, w_len_d;
  logic [7:0]       w_cnt_q, w_cnt_d;
  logic             w_err_q, w_err_d;
  logic             w_fire;
  logic             w_hit_len;
  logic             aw_ready;
  logic             w_ready;
  logic             b_valid;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    w_fire    = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    w_hit_len = (w_cnt_q == w_len_q);
    case (w_state_q)
      W_IDLE: begin
        aw_ready = !rst;
        if (s_axi.awvalid && !rst) begin
          w_idx_d   = word_idx(s_axi.awaddr);
          w_len_d   = s_axi.awlen;
          w_cnt_d   = 8'd0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = !rst;
        if (s_axi.wvalid && !rst) begin
          w_fire  = 1'b1;
          w_idx_d = w_idx_q + 1'b1;
          w_cnt_d = w_cnt_q + 8'd1;
          // The burst stops at whichever end marker comes first; the two
          // disagreeing means the master and awlen are out of step.
          if (s_axi.wlast || w_hit_len) begin
            w_err_d   = s_axi.wlast ^ w_hit_len;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        b_valid = !rst;
        if (s_axi.bready && !rst) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= 8'd0;
      w_cnt_q   <= 8'd0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // ----------------------------------------------------------------- read --
  r_state_e         r_state_q, r_state_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] rd_addr;
  logic [7:0]       rd_len_q, rd_len_d;
  logic [8:0]       rd_issued_q, rd_issued_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_pend_last_q, rd_pend_last_d;
  logic             rd_issue;
  logic             rd_pop;
  logic [2:0]       rd_occ;
  logic             ar_ready;
  logic [DW-1:0]    ram_dout_q;
  logic             skid_valid;
  logic [DW:0]      skid_data;
  logic [1:0]       skid_count;

  always_comb begin
    r_state_d      = r_state_q;
    rd_idx_d       = rd_idx_q;
    rd_len_d       = rd_len_q;
    rd_issued_d    = rd_issued_q;
    rd_pend_last_d = 1'b0;
    rd_addr        = rd_idx_q;
    rd_issue       = 1'b0;
    ar_ready       = 1'b0;
    rd_pop         = skid_valid & s_axi.rready & !rst;
    // Slots committed after this edge: the beat in flight plus buffered
    // beats, less the one leaving now. Counting the departing beat as free
    // is what sustains one beat per cycle.
    rd_occ = {2'b00, rd_pend_q} + {1'b0, skid_count} - {2'b00, rd_pop};
    case (r_state_q)
      R_IDLE: begin
        ar_ready = !rst;
        // The first RAM read is issued in the AR handshake cycle itself so
        // beat 0 is presented two cycles later.
        if (s_axi.arvalid && !rst) begin
          rd_issue       = 1'b1;
          rd_addr        = word_idx(s_axi.araddr);
          rd_pend_last_d = (s_axi.arlen == 8'd0);
          rd_idx_d       = rd_addr + 1'b1;
          rd_len_d       = s_axi.arlen;
          rd_issued_d    = 9'd1;
          r_state_d      = R_BURST;
        end
      end
      R_BURST: begin
        if (!rst && (rd_occ < 3'd2) && (rd_issued_q <= {1'b0, rd_len_q})) begin
          rd_issue       = 1'b1;
          rd_pend_last_d = (rd_issued_q[7:0] == rd_len_q);
          rd_idx_d       = rd_idx_q + 1'b1;
          rd_issued_d    = rd_issued_q + 9'd1;
        end
        if (rd_pop && skid_data[DW]) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    rd_pend_d = rd_issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q      <= R_IDLE;
      rd_idx_q       <= '0;
      rd_len_q       <= 8'd0;
      rd_issued_q    <= 9'd0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
    end else begin
      r_state_q      <= r_state_d;
      rd_idx_q       <= rd_idx_d;
      rd_len_q       <= rd_len_d;
      rd_issued_q    <= rd_issued_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
    end
  end

  // ------------------------------------------------------------------ RAM --
  // Both ports use non-blocking assignment, so a same-word read and write in
  // one cycle returns the old contents (read-first). Contents survive reset.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
    if (rd_issue) ram_dout_q <= mem[rd_addr];
  end

  axis_rd_skid #(
    .WIDTH (DW + 1)
  ) u_rd_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend_q),
    .in_data   ({rd_pend_last_q, ram_dout_q}),
    .out_valid (skid_valid),
    .out_ready (s_axi.rready & !rst),
    .out_data  (skid_data),
    .count     (skid_count)
  );

  // -------------------------------------------------------------- outputs --
  assign s_axi.awready = aw_ready;
  assign s_axi.wready  = w_ready;
  assign s_axi.bvalid  = b_valid;
  assign s_axi.bresp   = (b_valid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi.arready = ar_ready;
  assign s_axi.rvalid  = skid_valid & !rst;
  assign s_axi.rdata   = rst ? '0 : skid_data[DW-1:0];
  assign s_axi.rlast   = skid_valid & !rst & skid_data[DW];
  assign s_axi.rresp   = RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axis_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_mem_responder
// Description : Self-checking bench for axis_mem_responder (16-word memory):
//               table of single-beat write/read vectors plus directed burst,
//               backpressure, error, wrap and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axis_mem_responder #(
    .C_S_AXI_ADDR_WIDTH (32),
    .C_S_AXI_DATA_WIDTH (32),
    .C_MEM_WORDS        (16),
    .C_BASE_ADDR        (32'h0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] got_data [256];
  logic        got_last [256];
  logic [31:0] exp_data [256];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out, required handshake never came", name);
  endtask

  function automatic logic [31:0] ctl_outs();
    return {22'b0, bus.awready, bus.wready, bus.bvalid, bus.bresp,
            bus.arready, bus.rvalid, bus.rlast, bus.rresp};
  endfunction

  task automatic check_reset_outs(input string name);
    check({name, "_ctl"}, ctl_outs(), 32'h0);
    check({name, "_rdata"}, bus.rdata, 32'h0);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                          input int last_at, input logic [31:0] dbase, input logic [3:0] strb,
                          output logic [1:0] resp);
    int t;
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len;
    t = 0;
    while (!bus.awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) timeout("aw_handshake");
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wvalid = 1'b1; bus.wdata = dbase + 32'(i); bus.wstrb = strb; bus.wlast = (i == last_at);
      t = 0;
      while (!bus.wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) timeout("w_handshake");
      @(negedge clk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
    t = 0;
    while (!bus.bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin timeout("b_handshake"); resp = 2'b11; end
    else resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                         output int n, output int lat, output int span);
    int t, cyc, first_cyc;
    logic stalled, hold_l;
    logic [31:0] hold_d;
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len;
    t = 0;
    while (!bus.arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) timeout("ar_handshake");
    n = 0; lat = -1; cyc = 0; first_cyc = 0; span = 0;
    stalled = 1'b0; hold_l = 1'b0; hold_d = 32'h0;
    while (n <= int'(len) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.arvalid = 1'b0;
      bus.rready  = toggle ? (cyc % 3 == 1) : 1'b1;
      if (stalled) begin
        check("stall_rvalid", 32'(bus.rvalid), 32'h1);
        check("stall_rdata", bus.rdata, hold_d);
        check("stall_rlast", 32'(bus.rlast), 32'(hold_l));
      end
      if (bus.rvalid && lat < 0) lat = cyc;
      if (bus.rvalid && bus.rready) begin
        got_data[n] = bus.rdata;
        got_last[n] = bus.rlast;
        if (n == 0) first_cyc = cyc;
        span = cyc - first_cyc;
        n++;
      end
      stalled = bus.rvalid && !bus.rready;
      hold_d  = bus.rdata;
      hold_l  = bus.rlast;
    end
    if (cyc >= 400) timeout("r_beats");
    @(negedge clk);
    bus.rready = 1'b0;
    check("rd_done_arready", 32'(bus.arready), 32'h1);
    check("rd_done_rvalid", 32'(bus.rvalid), 32'h0);
  endtask

  task automatic check_beats(input string name, input int len);
    for (int j = 0; j <= len; j++) begin
      check({name, "_data"}, got_data[j], exp_data[j]);
      check({name, "_last"}, 32'(got_last[j]), 32'(j == len));
    end
  endtask

  initial begin
    logic [1:0] resp;
    int n, lat, span;

    bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.rready = 0;

    // Single-beat write then read-back; addr[1:0] ignored, index mod 16.
    vecs[0] = '{32'h0000_0010, 32'h0000_0000, 4'b1111, 2'b00, 32'h0000_0000};
    vecs[1] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 2'b00, 32'h0000_BEEF};
    vecs[2] = '{32'h0000_0012, 32'h1234_5678, 4'b1000, 2'b00, 32'h1200_BEEF};
    vecs[3] = '{32'h0000_0014, 32'hA5A5_A5A5, 4'b1111, 2'b00, 32'hA5A5_A5A5};
    vecs[4] = '{32'h0000_0054, 32'h1122_3344, 4'b0100, 2'b00, 32'hA522_A5A5};
    vecs[5] = '{32'h0000_0018, 32'hCAFE_F00D, 4'b1111, 2'b00, 32'hCAFE_F00D};

    // Reset state
    @(negedge clk);
    check_reset_outs("reset_hold");
    @(negedge clk);
    check_reset_outs("reset_hold2");
    rst = 1'b0;
    #1;
    check("post_reset_awready", 32'(bus.awready), 32'h1);
    check("post_reset_arready", 32'(bus.arready), 32'h1);

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      do_write(vecs[v].addr, 8'd0, 1, 0, vecs[v].wdata, vecs[v].strb, resp);
      check("vec_bresp", 32'(resp), 32'(vecs[v].bresp));
      do_read(vecs[v].addr, 8'd0, 1'b0, n, lat, span);
      check("vec_nbeats", 32'(n), 32'h1);
      check("vec_rdata", got_data[0], vecs[v].rdata);
      check("vec_rlast", 32'(got_last[0]), 32'h1);
      check("vec_latency", 32'(lat), 32'h2);
    end

    // 16-beat burst at 0x100 (word 0), streamed read-back
    do_write(32'h100, 8'd15, 16, 15, 32'h0, 4'b1111, resp);
    check("d2_bresp", 32'(resp), 32'h0);
    for (int j = 0; j < 16; j++) exp_data[j] = 32'(j);
    do_read(32'h100, 8'd15, 1'b0, n, lat, span);
    check("d2_nbeats", 32'(n), 32'd16);
    check("d2_latency", 32'(lat), 32'h2);
    check("d2_span", 32'(span), 32'd15);
    check_beats("d2", 15);

    // Same read under rready backpressure
    do_read(32'h100, 8'd15, 1'b1, n, lat, span);
    check("d3_nbeats", 32'(n), 32'd16);
    check_beats("d3", 15);

    // Early wlast: awlen=3, wlast on beat 1 at word 8
    do_write(32'h20, 8'd3, 2, 1, 32'hAAAA_0000, 4'b1111, resp);
    check("d4_early_bresp", 32'(resp), 32'h2);
    exp_data[0] = 32'hAAAA_0000; exp_data[1] = 32'hAAAA_0001;
    exp_data[2] = 32'h0000_000A; exp_data[3] = 32'h0000_000B;
    do_read(32'h20, 8'd3, 1'b0, n, lat, span);
    check_beats("d4", 3);
    // Missing wlast: awlen=1, no wlast
    do_write(32'h30, 8'd1, 2, -1, 32'hBBBB_0000, 4'b1111, resp);
    check("d4_nolast_bresp", 32'(resp), 32'h2);

    // Wrap: 4 beats from word 14
    do_write(32'h38, 8'd3, 4, 3, 32'hE0, 4'b1111, resp);
    check("d5_bresp", 32'(resp), 32'h0);
    for (int j = 0; j < 4; j++) exp_data[j] = 32'hE0 + 32'(j);
    do_read(32'h38, 8'd3, 1'b0, n, lat, span);
    check("d5_latency", 32'(lat), 32'h2);
    check_beats("d5", 3);
    exp_data[0] = 32'hE2; exp_data[1] = 32'hE3;
    do_read(32'h0, 8'd1, 1'b0, n, lat, span);
    check_beats("d5_word0", 1);

    // Reset in the middle of a stalled read burst
    bus.arvalid = 1'b1; bus.araddr = 32'h0; bus.arlen = 8'd15; bus.rready = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("d6_rd_active", 32'(bus.rvalid), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outs("d6_rd_rst");
    @(negedge clk);
    check_reset_outs("d6_rd_rst2");
    rst = 1'b0;
    #1;
    check("d6_rd_awready", 32'(bus.awready), 32'h1);
    check("d6_rd_arready", 32'(bus.arready), 32'h1);
    check("d6_rd_rvalid", 32'(bus.rvalid), 32'h0);

    // Reset in the middle of a write burst (one beat already accepted)
    bus.awvalid = 1'b1; bus.awaddr = 32'h20; bus.awlen = 8'd3;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h7777_7777; bus.wstrb = 4'b1111; bus.wlast = 1'b0;
    @(negedge clk);
    bus.wvalid = 1'b0;
    check("d6_wr_active", 32'(bus.wready), 32'h1);
    rst = 1'b1;
    #1;
    check_reset_outs("d6_wr_rst");
    @(negedge clk);
    check_reset_outs("d6_wr_rst2");
    rst = 1'b0;
    #1;
    check("d6_wr_awready", 32'(bus.awready), 32'h1);
    check("d6_wr_arready", 32'(bus.arready), 32'h1);
    check("d6_wr_bvalid", 32'(bus.bvalid), 32'h0);

    exp_data[0] = 32'h7777_7777; exp_data[1] = 32'hAAAA_0001;
    do_read(32'h20, 8'd1, 1'b0, n, lat, span);
    check_beats("d6_partial", 1);
    exp_data[0] = 32'hE0;
    do_read(32'h38, 8'd0, 1'b0, n, lat, span);
    check_beats("d6_kept", 0);
    do_write(32'h3C, 8'd0, 1, 0, 32'h5555_AAAA, 4'b1111, resp);
    check("d6_fresh_bresp", 32'(resp), 32'h0);
    exp_data[0] = 32'h5555_AAAA;
    do_read(32'h3C, 8'd0, 1'b0, n, lat, span);
    check_beats("d6_fresh", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axis_mem_responder.md
Name: axis_mem_responder

Overview:
AXI4 (full, INCR-only subset) slave memory model. It is the responder end of the vector/scalar AXI master ports driven by axim_ctrl and riscv_axif_m_ctrl.
It backs a parameterised word array in dual-port block RAM and serves one write burst and one read burst concurrently.
It is used as the DDR stand-in for system-level simulation of the processor, and as an on-chip scratch memory on FPGA.

Parameters:
C_S_AXI_ADDR_WIDTH, 32, byte address width.
C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
C_MEM_WORDS, 4096, memory depth in 32-bit words; must be a power of 2.
C_BASE_ADDR, 32'h0, byte address mapped to word 0.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
s_axi_awvalid  in  1  write address valid.
s_axi_awready  out  1  write address ready.
s_axi_awaddr  in  ADDR  write burst start byte address.
s_axi_awlen  in  8  write beats minus 1.
s_axi_wvalid  in  1  write data valid.
s_axi_wready  out  1  write data ready.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte enables.
s_axi_wlast  in  1  last write beat.
s_axi_bvalid  out  1  write response valid.
s_axi_bready  in  1  write response ready.
s_axi_bresp  out  2  write response code: OKAY = 00, SLVERR = 10.
s_axi_arvalid  in  1  read address valid.
s_axi_arready  out  1  read address ready.
s_axi_araddr  in  ADDR  read burst start byte address.
s_axi_arlen  in  8  read beats minus 1.
s_axi_rvalid  out  1  read data valid.
s_axi_rready  in  1  read data ready.
s_axi_rdata  out  32  read data.
s_axi_rlast  out  1  last read beat.
s_axi_rresp  out  2  always OKAY (00).

Behaviour:
Reset:
- Every output is 0 in any cycle where rst=1.
- Both FSMs return to IDLE, and the read buffer and beat counters are cleared.
- Memory contents are preserved; a burst in progress is abandoned with no response.
- awready and arready rise in the first cycle after rst falls.

Addressing:
- word index = ((addr - C_BASE_ADDR) >> 2) mod C_MEM_WORDS; addr[1:0] is ignored.
- The index increments by 1 per beat and wraps modulo C_MEM_WORDS; no error is raised on wrap.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: awready=1. On awvalid, latch the index and len, clear the beat count and the error flag, and go to W_DATA.
- W_DATA: wready=1. On each wvalid&wready, write the bytes of the current word that have wstrb set, then increment the index and the count.
- Burst end is the first of: wlast=1, or count==len. If exactly one of these is true on that beat, set the error flag. Either way go to W_RESP.
- W_RESP: bvalid=1 and bresp = SLVERR if the error flag is set, else OKAY. bvalid and bresp are held until bready, then go to W_IDLE.
- awready=0 outside W_IDLE: one outstanding write.
- W beats arriving while not in W_DATA are stalled (wready=0).

Read FSM (R_IDLE, R_BURST):
- R_IDLE: arready=1. On arvalid, latch the index and len, and go to R_BURST.
- R_BURST: issue one RAM read per cycle while (in-flight reads + buffer occupancy) < 2 and issued beats <= len.
- RAM read latency is 1 cycle. Results enter axis_rd_skid, a 2-entry buffer.
- rvalid = buffer not empty. rlast=1 on the beat whose beat number equals len.
- rdata and rlast stay stable while rvalid & !rready.
- First beat appears 2 cycles after the AR handshake. Throughput is 1 beat/cycle with rready held high.
- After the rlast handshake, go to R_IDLE; arready is 1 in the next cycle.

Collisions and ordering:
- Same-word read and write in the same cycle: the read returns old data (read-first port).
- Read and write channels are fully independent; no ordering between them is guaranteed.

Decomposition:
- axis_mem_responder_pkg: write/read state enums; RESP_OKAY and RESP_SLVERR constants; the word-index width function clog2(C_MEM_WORDS).
- Sub-module axis_rd_skid: a 2-entry valid/ready buffer carrying {rlast, rdata}, with count output.
- RAM: an inferred dual-port array in the top module.

Test Plan:
- Directed 1: AW addr 0x10, len 0; W 0xDEADBEEF, wstrb 0011, wlast. Then AR 0x10, len 0. Required: bresp 00; rdata 0x0000BEEF (memory pre-zeroed); rlast=1.
- Directed 2: write 16 beats at 0x100 with data i; read back len 15 with rready held 1. Required: 16 consecutive rvalid cycles, data 0..15, rlast only on beat 15, first beat 2 cycles after AR.
- Directed 3: repeat the read with rready toggling 1,0,0,1,… Required: rdata/rlast stable while stalled; no beat lost or duplicated.
- Directed 4: awlen=3 with wlast on beat 1. Required: burst ends after 2 beats, bresp 10, words 2–3 untouched. Also awlen=1 without wlast: bresp 10.
- Directed 5: C_MEM_WORDS=16; write 4 beats starting at word 14. Required: words 14, 15, 0, 1 written; reading back returns the same data.
- Directed 6: assert rst in the middle of a read burst and in the middle of a write burst. Required: all outputs 0 during reset; awready and arready =1 the cycle after; earlier written data still readable.
